// File: rtl/mem_dump_pkg.sv
// mem_dump_pkg: shared state encoding and sizing constants for the TCM dump reader
package mem_dump_pkg;
    localparam int BYTES_PER_WORD    = 4;
    localparam int MEM_BYTES_DEFAULT = 131072;
    typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} state_t;
endpackage

// File: rtl/mem_dump_reader_word_serializer.sv
// word_serializer: splits a 32-bit word into four bytes, LSB first, with valid/ready handshake
module word_serializer
    import mem_dump_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load,
    input  logic [31:0] word,
    input  logic        ready,
    output logic [7:0]  data_o,
    output logic        valid_o,
    output logic        last
);
    logic [31:0] shift;
    logic [1:0]  idx;
    logic        xfer;
    assign xfer   = valid_o & ready;
    assign last   = xfer & (idx == 2'(BYTES_PER_WORD - 1));
    assign data_o = shift[7:0];
    // load a fresh word, then shift one byte out per accepted transfer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift   <= '0;
            idx     <= '0;
            valid_o <= 1'b0;
        end else if (load) begin
            shift   <= word;
            idx     <= '0;
            valid_o <= 1'b1;
        end else if (xfer) begin
            shift   <= shift >> 8;
            idx     <= idx + 2'd1;
            valid_o <= ~last;
        end
    end
endmodule

// File: rtl/mem_dump_reader.sv
// mem_dump_reader: reads a word range from the TCM and streams it out as little-endian bytes
module mem_dump_reader
    import mem_dump_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
    parameter int LEN_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      base_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [31:0]      mem_addr_o,
    output logic             mem_rd_o,
    output logic [3:0]       mem_wr_o,
    input  logic [31:0]      mem_data_i,
    output logic [7:0]       byte_o,
    output logic             byte_valid_o,
    input  logic             byte_ready_i
);
    localparam int AW = $clog2(MEM_BYTES);

    state_t           state;
    logic [AW-1:0]    addr;
    logic [AW-1:0]    addr_next;
    logic [AW-1:0]    base_aligned;
    logic [LEN_W-1:0] remaining;
    logic             last;
    logic             unused_base;

    assign base_aligned = {base_i[AW-1:2], 2'b00};
    assign addr_next    = addr + AW'(BYTES_PER_WORD);
    assign mem_wr_o     = 4'b0000;
    assign unused_base  = ^{base_i[31:AW], base_i[1:0]};

    word_serializer u_ser (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load    (state == WAIT),
        .word    (mem_data_i),
        .ready   (byte_ready_i),
        .data_o  (byte_o),
        .valid_o (byte_valid_o),
        .last    (last)
    );

    // dump sequencer: one read per word, wait for data, hand the word to the serializer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            addr       <= '0;
            remaining  <= '0;
            mem_addr_o <= '0;
            mem_rd_o   <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    addr      <= base_aligned;
                    remaining <= len_i;
                    busy_o    <= 1'b1;
                    if (len_i == '0) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end else begin
                        state      <= READ;
                        mem_rd_o   <= 1'b1;
                        mem_addr_o <= 32'(base_aligned);
                    end
                end
                READ: begin
                    state    <= WAIT;
                    mem_rd_o <= 1'b0;
                end
                WAIT: state <= SEND;
                SEND: if (last) begin
                    remaining <= remaining - LEN_W'(1);
                    addr      <= addr_next;
                    if (remaining == LEN_W'(1)) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end else begin
                        state      <= READ;
                        mem_rd_o   <= 1'b1;
                        mem_addr_o <= 32'(addr_next);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_dump_reader.sv
// tb_mem_dump_reader: scoreboard bench with a word-array TCM model and randomized dumps
module tb_mem_dump_reader;
    localparam int MEM_BYTES = 1024;
    localparam int LEN_W     = 16;
    localparam int WORDS     = MEM_BYTES / 4;
    localparam int AW        = $clog2(MEM_BYTES);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [31:0]      base = '0;
    logic [LEN_W-1:0] len = '0;
    logic             ready = 1'b1;
    logic [31:0]      mem_data = '0;
    logic             busy, done, mem_rd, valid;
    logic [31:0]      mem_addr;
    logic [3:0]       mem_wr;
    logic [7:0]       byte_out;

    mem_dump_reader #(.MEM_BYTES(MEM_BYTES), .LEN_W(LEN_W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .base_i(base), .len_i(len),
        .busy_o(busy), .done_o(done), .mem_addr_o(mem_addr), .mem_rd_o(mem_rd),
        .mem_wr_o(mem_wr), .mem_data_i(mem_data), .byte_o(byte_out),
        .byte_valid_o(valid), .byte_ready_i(ready)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0, cyc = 0;
    logic [31:0] mem [WORDS];
    logic [7:0]  exp_bytes [$];
    logic [31:0] exp_addr [$];
    int          first_valid_cyc, done_cyc, busy_cnt, rd_cnt, done_cnt;
    bit          seen_valid, hold_pending;
    logic [7:0]  held;
    int          ready_mode = 0, pat_idx = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // TCM model: data appears the cycle after a read strobe, garbage otherwise
    always @(posedge clk) mem_data <= mem_rd ? mem[mem_addr[AW-1:2]] : $urandom;

    // sink readiness: always, random, or the repeating 1,0,0,1 pattern
    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) ready = 1'b1;
        else if (ready_mode == 1) ready = 1'($urandom_range(0, 1));
        else begin
            ready = (pat_idx == 0) || (pat_idx == 3);
            pat_idx = (pat_idx + 1) % 4;
        end
    end

    // monitor: pops the scoreboard on every read strobe and every byte transfer
    always @(negedge clk) begin
        if (!rst) begin
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (mem_wr !== 4'b0000) chk("mem_wr", 32'(mem_wr), 0);
            if (mem_rd) begin
                rd_cnt++;
                if (exp_addr.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("rd_addr", mem_addr, exp_addr.pop_front());
            end
            if (valid && !seen_valid) begin seen_valid = 1; first_valid_cyc = cyc; end
            if (hold_pending) begin
                chk("byte_stable", {23'd0, valid, byte_out}, {23'd0, 1'b1, held});
                hold_pending = 0;
            end
            if (valid && ready) begin
                if (exp_bytes.size() == 0) chk("byte_unexpected", 1, 0);
                else chk("byte", 32'(byte_out), 32'(exp_bytes.pop_front()));
            end else if (valid) begin
                hold_pending = 1;
                held = byte_out;
            end
        end
    end

    task automatic push_expect(input logic [31:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            longint unsigned a = ((longint'(b) & 64'hFFFF_FFFC) + 4 * i) % MEM_BYTES;
            logic [31:0] w = mem[a / 4];
            exp_addr.push_back(32'(a));
            for (int k = 0; k < 4; k++) exp_bytes.push_back(8'(w >> (8 * k)));
        end
    endtask

    task automatic issue(input logic [31:0] b, input int n, output int t0);
        tick();
        seen_valid = 0; busy_cnt = 0; rd_cnt = 0; done_cnt = 0;
        start = 1'b1; base = b; len = LEN_W'(n);
        push_expect(b, n);
        tick();
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic run(input logic [31:0] b, input int n, input int mode, input bit lat, input bit intrude);
        int t0;
        int i;
        ready_mode = mode;
        issue(b, n, t0);
        for (i = 0; i < 20000 && done_cnt == 0; i++) begin
            if (intrude && i == 1) begin
                start = 1'b1; base = $urandom; len = LEN_W'($urandom_range(1, 9));
            end else start = 1'b0;
            tick();
        end
        start = 1'b0;
        if (done_cnt == 0) chk("done_timeout", 0, 1);
        if (lat) begin
            if (n > 0) chk("first_byte_latency", first_valid_cyc - t0, 2);
            chk("done_latency", done_cyc - t0, 6 * n);
            chk("busy_cycles", busy_cnt, 6 * n + 1);
        end
        tick();
        chk("done_pulse_count", done_cnt, 1);
        chk("idle_after_done", {30'd0, busy, done}, 0);
        chk("rd_count", rd_cnt, n);
        chk("bytes_left", exp_bytes.size(), 0);
        chk("addrs_left", exp_addr.size(), 0);
        exp_bytes.delete();
        exp_addr.delete();
    endtask

    task automatic check_outputs_zero(input string name);
        chk(name, {busy, done, mem_rd, valid, byte_out, mem_wr}, 0);
        chk({name, "_addr"}, mem_addr, 0);
    endtask

    initial begin
        int t0;
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        mem[32'h100 / 4] = 32'hDDCC_BBAA;
        repeat (3) tick();
        check_outputs_zero("reset_state");
        rst = 1'b0;
        tick();

        run(32'h100, 1, 0, 1, 0);
        run(32'h103, 1, 2, 0, 0);
        run(MEM_BYTES - 4, 2, 0, 1, 0);
        run(32'h40, 0, 0, 1, 0);
        run(32'h200, 3, 0, 1, 1);

        ready_mode = 0;
        issue(32'h80, 4, t0);
        for (int i = 0; i < 100 && exp_bytes.size() > 15; i++) tick();
        chk("mid_dump_reached", exp_bytes.size(), 15);
        rst = 1'b1; start = 1'b1; base = 32'h300; len = 5;
        tick();
        check_outputs_zero("reset_mid_dump");
        exp_bytes.delete(); exp_addr.delete(); hold_pending = 0;
        rst = 1'b0; start = 1'b0;
        tick();
        chk("start_during_reset_ignored", {31'd0, busy}, 0);
        run(32'h80, 4, 0, 1, 0);

        for (int r = 0; r < 12; r++) begin
            int m = $urandom_range(0, 2);
            run($urandom, $urandom_range(0, 5), m, m == 0, r[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
